// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the unified SRAM port arbiter.
package arb_pkg;

  typedef enum logic {IDLE, WAIT} state_e;
  typedef enum logic {OWN_INST, OWN_DATA} owner_e;

  function automatic int lat_cnt_w(input int mem_lat);
    return $clog2(mem_lat + 1);
  endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Data-first pick between fetch and data requesters, with a fetch starvation guard.
// Grants are combinational and only issued while en_i is high; the starve counter is registered.
module arb_prio_pick #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic inst_req_i,
  input  logic data_req_i,
  output logic grant_inst_o,
  output logic grant_data_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          starved;

  assign starved      = (starve_q == SW'(STARVE_LIMIT));
  assign grant_inst_o = en_i && inst_req_i && (!data_req_i || starved);
  assign grant_data_o = en_i && data_req_i && !grant_inst_o;

  // Only counts data wins that actually made a waiting fetch wait longer.
  always_comb begin
    starve_d = starve_q;
    if (en_i) begin
      if (grant_inst_o || !inst_req_i) begin
        starve_d = '0;
      end else if (grant_data_o) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported synchronous SRAM between instruction fetch and data access.
// Grants in the IDLE cycle; data_ok pulses MEM_LAT+1 cycles after addr_ok; no accepts while busy.
module sram_port_arbiter
  import arb_pkg::*;
#(
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  localparam int CW = lat_cnt_w(MEM_LAT);

  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $fatal(1, "sram_port_arbiter: MEM_LAT must be at least 1");
  end

  state_e        state_q;
  owner_e        owner_q;
  logic [CW-1:0] cnt_q;
  logic          inst_ok_q, data_ok_q;
  logic [31:0]   inst_rdata_q, data_rdata_q;
  logic          idle, grant_inst, grant_data;

  // Holding rst also gates every combinational output through the grants.
  assign idle = (state_q == IDLE) && !rst;

  arb_prio_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk         (clk),
    .rst         (rst),
    .en_i        (idle),
    .inst_req_i  (inst_req),
    .data_req_i  (data_req),
    .grant_inst_o(grant_inst),
    .grant_data_o(grant_data)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_data) begin
      mem_en    = 1'b1;
      mem_wen   = data_wr ? data_wen : 4'b0000;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else if (grant_inst) begin
      mem_en   = 1'b1;
      mem_addr = inst_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_INST;
      cnt_q        <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      inst_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_inst || grant_data) begin
            owner_q <= grant_data ? OWN_DATA : OWN_INST;
            cnt_q   <= CW'(MEM_LAT);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          // Last wait cycle: mem_rdata is valid now, completion shows next cycle.
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            if (owner_q == OWN_DATA) begin
              data_ok_q    <= 1'b1;
              data_rdata_q <= mem_rdata;
            end else begin
              inst_ok_q    <= 1'b1;
              inst_rdata_q <= mem_rdata;
            end
          end
        end
      endcase
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = inst_ok_q;
  assign data_data_ok = data_ok_q;
  assign inst_rdata   = inst_rdata_q;
  assign data_rdata   = data_rdata_q;
  assign busy         = (state_q == WAIT);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: a MEM_LAT=1 and a MEM_LAT=3 instance against a transaction-level model.
module tb_sram_port_arbiter;
  localparam int LIMIT = 4;
  localparam int NCYC  = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req     [2];
  logic [31:0] inst_addr    [2];
  logic        inst_addr_ok [2];
  logic        inst_data_ok [2];
  logic [31:0] inst_rdata   [2];
  logic        data_req     [2];
  logic        data_wr      [2];
  logic [3:0]  data_wen     [2];
  logic [31:0] data_addr    [2];
  logic [31:0] data_wdata   [2];
  logic        data_addr_ok [2];
  logic        data_data_ok [2];
  logic [31:0] data_rdata   [2];
  logic        mem_en       [2];
  logic [3:0]  mem_wen      [2];
  logic [31:0] mem_addr     [2];
  logic [31:0] mem_wdata    [2];
  logic [31:0] mem_rdata    [2];
  logic        busy         [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_port_arbiter #(
      .MEM_LAT     ((g == 0) ? 1 : 3),
      .STARVE_LIMIT(LIMIT)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req[g]),
      .inst_addr   (inst_addr[g]),
      .inst_addr_ok(inst_addr_ok[g]),
      .inst_data_ok(inst_data_ok[g]),
      .inst_rdata  (inst_rdata[g]),
      .data_req    (data_req[g]),
      .data_wr     (data_wr[g]),
      .data_wen    (data_wen[g]),
      .data_addr   (data_addr[g]),
      .data_wdata  (data_wdata[g]),
      .data_addr_ok(data_addr_ok[g]),
      .data_data_ok(data_data_ok[g]),
      .data_rdata  (data_rdata[g]),
      .mem_en      (mem_en[g]),
      .mem_wen     (mem_wen[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata[g]),
      .busy        (busy[g])
    );
  end

  function automatic void chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cyc=%0d: got %h, want %h", nm, idx, cyc, act, exp);
    end
  endfunction

  // Model: one access in flight, completing at accept+lat+1; capture mem_rdata the cycle before.
  int          m_done     [2];
  int          m_starve   [2];
  bit          m_own_data [2];
  logic [31:0] m_irdata   [2];
  logic [31:0] m_drdata   [2];
  bit          inst_acc   [2];
  bit          data_acc   [2];

  function automatic int lat_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit fr, gi, gd;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_wen;
      if (rst) begin
        chk("rst_inst_addr_ok", i, inst_addr_ok[i], 0);
        chk("rst_data_addr_ok", i, data_addr_ok[i], 0);
        chk("rst_inst_data_ok", i, inst_data_ok[i], 0);
        chk("rst_data_data_ok", i, data_data_ok[i], 0);
        chk("rst_inst_rdata", i, inst_rdata[i], 0);
        chk("rst_data_rdata", i, data_rdata[i], 0);
        chk("rst_mem_en", i, mem_en[i], 0);
        chk("rst_mem_wen", i, mem_wen[i], 0);
        chk("rst_mem_addr", i, mem_addr[i], 0);
        chk("rst_mem_wdata", i, mem_wdata[i], 0);
        chk("rst_busy", i, busy[i], 0);
        m_done[i]     = -1000;
        m_starve[i]   = 0;
        m_own_data[i] = 1'b0;
        m_irdata[i]   = '0;
        m_drdata[i]   = '0;
      end else begin
        fr      = (cyc >= m_done[i]);
        gi      = fr && inst_req[i] && (!data_req[i] || m_starve[i] == LIMIT);
        gd      = fr && data_req[i] && !gi;
        e_addr  = gd ? data_addr[i] : (gi ? inst_addr[i] : 32'h0);
        e_wdata = gd ? data_wdata[i] : 32'h0;
        e_wen   = (gd && data_wr[i]) ? data_wen[i] : 4'h0;
        chk("inst_addr_ok", i, inst_addr_ok[i], gi);
        chk("data_addr_ok", i, data_addr_ok[i], gd);
        chk("inst_data_ok", i, inst_data_ok[i], (cyc == m_done[i]) && !m_own_data[i]);
        chk("data_data_ok", i, data_data_ok[i], (cyc == m_done[i]) && m_own_data[i]);
        chk("inst_rdata", i, inst_rdata[i], m_irdata[i]);
        chk("data_rdata", i, data_rdata[i], m_drdata[i]);
        chk("mem_en", i, mem_en[i], gi || gd);
        chk("mem_wen", i, mem_wen[i], e_wen);
        chk("mem_addr", i, mem_addr[i], e_addr);
        chk("mem_wdata", i, mem_wdata[i], e_wdata);
        chk("busy", i, busy[i], !fr);
        if (!fr && cyc == m_done[i] - 1) begin
          if (m_own_data[i]) m_drdata[i] = mem_rdata[i];
          else               m_irdata[i] = mem_rdata[i];
        end
        if (fr) begin
          if (gi || !inst_req[i]) m_starve[i] = 0;
          else if (gd)            m_starve[i]++;
        end
        if (gi || gd) begin
          m_done[i]     = cyc + lat_of(i) + 1;
          m_own_data[i] = gd;
        end
      end
      inst_acc[i] = inst_addr_ok[i];
      data_acc[i] = data_addr_ok[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    mem_rdata[0] = $urandom;
    mem_rdata[1] = $urandom;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      inst_req[i]   = 1'b0;
      inst_addr[i]  = '0;
      data_req[i]   = 1'b0;
      data_wr[i]    = 1'b0;
      data_wen[i]   = '0;
      data_addr[i]  = '0;
      data_wdata[i] = '0;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    mem_rdata[0] = '0;
    mem_rdata[1] = '0;
    inst_req[0]  = 1'b1;
    data_req[0]  = 1'b1;
    data_addr[0] = 32'h80000000;
    repeat (2) tick();
    @(negedge clk);
    chk("reset_inst_gate", 0, inst_addr_ok[0], 0);
    chk("reset_mem_en_gate", 0, mem_en[0], 0);
    chk("reset_mem_addr_gate", 0, mem_addr[0], 0);
    tick();
    rst = 1'b0;
    idle_all();
    tick();

    // Lone fetch
    inst_req[0]  = 1'b1;
    inst_addr[0] = 32'hBFC00000;
    @(negedge clk);
    chk("t1_addr_ok", 0, inst_addr_ok[0], 1);
    chk("t1_mem_en", 0, mem_en[0], 1);
    chk("t1_mem_wen", 0, mem_wen[0], 0);
    chk("t1_mem_addr", 0, mem_addr[0], 32'hBFC00000);
    tick();
    inst_req[0]  = 1'b0;
    mem_rdata[0] = 32'h24080001;
    @(negedge clk);
    chk("t1_early_ok", 0, inst_data_ok[0], 0);
    chk("t1_busy", 0, busy[0], 1);
    tick();
    @(negedge clk);
    chk("t1_data_ok", 0, inst_data_ok[0], 1);
    chk("t1_rdata", 0, inst_rdata[0], 32'h24080001);

    // Simultaneous data read and fetch
    tick();
    data_req[0]  = 1'b1;
    data_wr[0]   = 1'b0;
    data_addr[0] = 32'h80000010;
    inst_req[0]  = 1'b1;
    inst_addr[0] = 32'hBFC00004;
    @(negedge clk);
    chk("t2_data_addr_ok", 0, data_addr_ok[0], 1);
    chk("t2_inst_waits", 0, inst_addr_ok[0], 0);
    tick();
    data_req[0] = 1'b0;
    tick();
    @(negedge clk);
    chk("t2_data_ok", 0, data_data_ok[0], 1);
    chk("t2_inst_addr_ok", 0, inst_addr_ok[0], 1);
    tick();
    inst_req[0] = 1'b0;
    tick();
    @(negedge clk);
    chk("t2_inst_data_ok", 0, inst_data_ok[0], 1);
    chk("t2_no_data_ok", 0, data_data_ok[0], 0);

    // Byte-enabled write
    tick();
    data_req[0]   = 1'b1;
    data_wr[0]    = 1'b1;
    data_wen[0]   = 4'b0011;
    data_addr[0]  = 32'h80000020;
    data_wdata[0] = 32'h1234ABCD;
    @(negedge clk);
    chk("t3_mem_wen", 0, mem_wen[0], 4'b0011);
    chk("t3_mem_addr", 0, mem_addr[0], 32'h80000020);
    chk("t3_mem_wdata", 0, mem_wdata[0], 32'h1234ABCD);
    chk("t3_inst_addr_ok", 0, inst_addr_ok[0], 0);
    tick();
    data_req[0] = 1'b0;
    data_wr[0]  = 1'b0;
    tick();
    @(negedge clk);
    chk("t3_data_ok", 0, data_data_ok[0], 1);
    chk("t3_inst_data_ok", 0, inst_data_ok[0], 0);

    // Starvation guard: four data grants then a forced fetch
    tick();
    inst_req[0]  = 1'b1;
    inst_addr[0] = 32'hBFC00008;
    data_req[0]  = 1'b1;
    data_addr[0] = 32'h80000100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t4_inst_grant", 0, inst_addr_ok[0], (k == 4));
      chk("t4_data_grant", 0, data_addr_ok[0], (k != 4));
      tick();
      if (k == 4) inst_req[0] = 1'b0;
      if (k == 5) data_req[0] = 1'b0;
      tick();
    end

    // Reset during WAIT
    tick();
    inst_req[0]  = 1'b1;
    inst_addr[0] = 32'hBFC00010;
    @(negedge clk);
    chk("t5_accept", 0, inst_addr_ok[0], 1);
    tick();
    inst_req[0] = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    chk("t5_busy_cleared", 0, busy[0], 0);
    chk("t5_no_ok_rst", 0, inst_data_ok[0], 0);
    tick();
    @(negedge clk);
    chk("t5_no_ok_a", 0, inst_data_ok[0], 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_ok_b", 0, inst_data_ok[0], 0);
    tick();
    @(negedge clk);
    chk("t5_no_ok_c", 0, inst_data_ok[0], 0);
    tick();
    inst_req[0]  = 1'b1;
    inst_addr[0] = 32'hBFC00014;
    @(negedge clk);
    chk("t5_re_accept", 0, inst_addr_ok[0], 1);
    tick();
    inst_req[0]  = 1'b0;
    mem_rdata[0] = 32'h3C1D8000;
    tick();
    @(negedge clk);
    chk("t5_re_ok", 0, inst_data_ok[0], 1);
    chk("t5_re_rdata", 0, inst_rdata[0], 32'h3C1D8000);

    // MEM_LAT=3 instance, request held to probe the earliest re-accept
    tick();
    data_req[1]  = 1'b1;
    data_wr[1]   = 1'b0;
    data_addr[1] = 32'h80000030;
    @(negedge clk);
    chk("t6_accept", 1, data_addr_ok[1], 1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) mem_rdata[1] = 32'hCAFEF00D;
      @(negedge clk);
      chk("t6_busy", 1, busy[1], 1);
      chk("t6_no_accept", 1, data_addr_ok[1], 0);
      chk("t6_no_ok", 1, data_data_ok[1], 0);
    end
    tick();
    @(negedge clk);
    chk("t6_data_ok", 1, data_data_ok[1], 1);
    chk("t6_rdata", 1, data_rdata[1], 32'hCAFEF00D);
    chk("t6_second_accept", 1, data_addr_ok[1], 1);
    chk("t6_idle", 1, busy[1], 0);
    tick();
    data_req[1] = 1'b0;
    tick();

    // Random traffic on both instances with rare resets
    for (int c = 0; c < NCYC; c++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!inst_req[i] || inst_acc[i]) begin
          inst_req[i]  = ($urandom_range(0, 9) < 6);
          inst_addr[i] = $urandom;
        end
        if (!data_req[i] || data_acc[i]) begin
          data_req[i]   = ($urandom_range(0, 9) < 7);
          data_wr[i]    = $urandom_range(0, 1);
          data_wen[i]   = 4'($urandom);
          data_addr[i]  = $urandom;
          data_wdata[i] = $urandom;
        end
      end
    end
    tick();
    rst = 1'b0;
    idle_all();
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
